mask_decompose: RTL and testbench

Serial bit-mask decomposer for the processor datapath. It accepts a 32-bit mask, such as an OR-accumulated pending/status word, and emits the one-hot components of that mask back out, one per beat, together with each bit's index. Input and output both use a valid/ready handshake. The block sits beside the ALU logic units and feeds sequential consumers: exception/interrupt dispatch and register-scoreboard release.

---
 rtl/mask_decompose.sv | 114 +++++++++++
 tb/tb_mask_decompose.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mask_decompose.sv
// rtl/mask_decompose.sv - serial one-hot decomposer of a 32-bit mask with valid/ready handshakes
// Optional build macro MASK_DECOMPOSE_MSB_FIRST_EN selects descending (MSB-first) emission order.
module mask_decompose #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bit,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic [IDXW:0]    out_total,
    output logic             zero_pulse
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] residual_q, residual_d;
    logic [IDXW:0]    total_q, total_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] pick_bit;
    logic [IDXW-1:0]  pick_idx;
    logic [IDXW:0]    in_popcount;
    logic             single_bit;

    // residual_q is zero whenever the FSM is idle, so the beat outputs read as zero there.
    always_comb begin
        pick_bit = '0;
        pick_idx = '0;
`ifdef MASK_DECOMPOSE_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (residual_q[i]) pick_idx = IDXW'(i);
        end
        pick_bit = (residual_q == '0) ? '0 : (WIDTH'(1) << pick_idx);
`else
        pick_bit = residual_q & (~residual_q + WIDTH'(1));
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (residual_q[i]) pick_idx = IDXW'(i);
        end
`endif
    end

    always_comb begin
        in_popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_popcount = in_popcount + (IDXW+1)'(in_mask[i]);
        end
    end

    assign single_bit = (residual_q != '0) &&
                        ((residual_q & (residual_q - WIDTH'(1))) == '0);

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        total_d    = total_q;
        zero_d     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    residual_d = in_mask;
                    total_d    = in_popcount;
                    zero_d     = (in_mask == '0);
                    state_d    = (in_mask == '0) ? IDLE : EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    residual_d = residual_q & ~pick_bit;
                    if (single_bit) begin
                        residual_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            residual_q <= '0;
            total_q    <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            total_q    <= total_d;
            zero_q     <= zero_d;
        end
    end

    assign out_bit    = pick_bit;
    assign out_index  = pick_idx;
    assign out_last   = single_bit;
    assign out_total  = total_q;
    assign zero_pulse = zero_q;

endmodule

// File: tb/tb_mask_decompose.sv
// tb/tb_mask_decompose.sv - randomized self-checking bench for mask_decompose against a queue model
module tb_mask_decompose;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_mask = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_bit;
    logic [4:0]  out_index;
    logic        out_last;
    logic [5:0]  out_total;
    logic        zero_pulse;

    int errors = 0;
    int checks = 0;

    // Reference: pending bit indices in emission order, plus latched total and pulse.
    int mq[$];
    int mtot = 0;
    bit mzp = 1'b0;

    mask_decompose #(.WIDTH(32), .IDXW(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_total  (out_total),
        .zero_pulse (zero_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic        ev;
        logic [31:0] eb;
        logic [4:0]  ei;
        ev = (mq.size() != 0);
        eb = '0;
        ei = '0;
        if (ev) begin
            eb = 32'd1 << mq[0];
            ei = 5'(mq[0]);
        end
        check({tag, ".in_ready"},   64'(in_ready),   64'(!ev));
        check({tag, ".out_valid"},  64'(out_valid),  64'(ev));
        check({tag, ".out_bit"},    64'(out_bit),    64'(eb));
        check({tag, ".out_index"},  64'(out_index),  64'(ei));
        check({tag, ".out_last"},   64'(out_last),   64'(mq.size() == 1));
        check({tag, ".out_total"},  64'(out_total),  64'(mtot));
        check({tag, ".zero_pulse"}, 64'(zero_pulse), 64'(mzp));
    endtask

    task automatic load_model(input logic [31:0] m);
        mq.delete();
        mtot = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                mtot++;
`ifdef MASK_DECOMPOSE_MSB_FIRST_EN
                mq.push_front(i);
`else
                mq.push_back(i);
`endif
            end
        end
        mzp = (m == 32'd0);
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] m, input logic r);
        in_valid  = v;
        in_mask   = m;
        out_ready = r;
        @(posedge clock);
        mzp = 1'b0;
        if (mq.size() == 0) begin
            if (v) load_model(m);
        end else if (r) begin
            void'(mq.pop_front());
        end
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        mtot = 0;
        mzp  = 1'b0;
    endtask

    initial begin
        logic [31:0] rm;

        // Reset held with random inputs.
        model_reset();
        for (int c = 0; c < 4; c++) begin
            in_valid  = 1'($urandom);
            in_mask   = $urandom;
            out_ready = 1'($urandom);
            @(negedge clock);
            check_all("reset");
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        for (int c = 0; c < 3; c++) step("post_reset", 1'b0, $urandom, 1'($urandom));

        // Sparse mask.
        step("sparse_acc", 1'b1, 32'h8000_0021, 1'b1);
`ifdef MASK_DECOMPOSE_MSB_FIRST_EN
        check("sparse_first_bit", 64'(out_bit), 64'h8000_0000);
`else
        check("sparse_first_bit", 64'(out_bit), 64'h1);
`endif
        check("sparse_total", 64'(out_total), 64'd3);
        for (int c = 0; c < 4; c++) step("sparse", 1'b0, 32'h0, 1'b1);

        // Backpressure.
        step("bp_acc", 1'b1, 32'h6, 1'b0);
        step("bp", 1'b0, 32'h0, 1'b0);
        step("bp", 1'b0, 32'h0, 1'b0);
        step("bp", 1'b0, 32'h0, 1'b1);
        check("bp_second_beat", 64'(out_bit), 64'((mq.size() != 0) ? (32'd1 << mq[0]) : 32'd0));
        step("bp", 1'b0, 32'h0, 1'b0);
        step("bp", 1'b0, 32'h0, 1'b1);
        step("bp_idle", 1'b0, 32'h0, 1'b1);

        // Zero masks back to back, then full mask.
        step("zero", 1'b1, 32'h0, 1'b1);
        check("zero_pulse_hi", 64'(zero_pulse), 64'd1);
        step("zero2", 1'b1, 32'h0, 1'b1);
        step("zero_end", 1'b0, 32'h0, 1'b1);
        check("zero_pulse_lo", 64'(zero_pulse), 64'd0);
        step("full_acc", 1'b1, 32'hFFFF_FFFF, 1'b1);
        check("full_total", 64'(out_total), 64'd32);
        for (int c = 0; c < 33; c++) step("full", 1'b0, 32'h0, 1'b1);

        // Back-to-back with in_valid held.
        step("b2b_acc", 1'b1, 32'h3, 1'b1);
        for (int c = 0; c < 5; c++) step("b2b", 1'b1, 32'h10, 1'b1);
        step("b2b_end", 1'b0, 32'h0, 1'b1);

        // Reset mid-operation.
        step("rst_acc", 1'b1, 32'hF0, 1'b1);
        step("rst_beat", 1'b0, 32'h0, 1'b1);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) step("rst_after", 1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: rm = 32'h0;
                1: rm = 32'd1 << $urandom_range(0, 31);
                2: rm = $urandom & $urandom & $urandom;
                default: rm = $urandom;
            endcase
            step("rand", 1'($urandom_range(0, 3) == 0), rm, 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
